// File: rtl/hero_attack_ctl_pkg.sv
// Shared game geometry and encodings for the hero attack generator.
// Heroes are kept inside the 62..962 (x) / 108..708 (y) playfield by the hero
// controllers, so unclamped sums below never wrap 12 bits.
package hero_attack_ctl_pkg;

  localparam logic [11:0] SQUARE_SIDE   = 12'd60;
  localparam logic [11:0] ATTACK_WIDTH  = 12'd40;
  localparam logic [11:0] ATTACK_HEIGHT = 12'd20;
  localparam logic [11:0] PARK_X        = 12'd1100;
  localparam logic [11:0] PARK_Y        = 12'd0;

  typedef enum logic [1:0] {
    FACE_UP    = 2'b00,
    FACE_LEFT  = 2'b01,
    FACE_RIGHT = 2'b10,
    FACE_DOWN  = 2'b11
  } facing_t;

  typedef enum logic [1:0] {
    ST_READY    = 2'b00,
    ST_ACTIVE   = 2'b01,
    ST_COOLDOWN = 2'b10
  } state_t;

  // Swap LEFT and RIGHT for the mirrored hero; UP and DOWN pass through.
  function automatic logic [1:0] mirror_facing(input logic [1:0] f);
    return ((f == FACE_LEFT) || (f == FACE_RIGHT)) ? ~f : f;
  endfunction

  // Horizontal facings produce the wide 40x20 rectangle.
  function automatic logic is_horizontal(input logic [1:0] f);
    return (f == FACE_LEFT) || (f == FACE_RIGHT);
  endfunction

endpackage

// File: rtl/hero_attack_ctl_attack_offset.sv
// attack_offset: hero position + facing -> attack rectangle top-left corner.
// Purely combinational; subtractions saturate at 0, sums are not clamped.
module attack_offset
  import hero_attack_ctl_pkg::*;
(
  input  logic [11:0] hx,
  input  logic [11:0] hy,
  input  logic [1:0]  face,
  output logic [11:0] ax,
  output logic [11:0] ay
);

  function automatic logic [11:0] sub_clamp(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? 12'd0 : a - b;
  endfunction

  // Select the offset pair for the requested facing.
  always_comb begin
    ax = hx + ATTACK_HEIGHT;
    ay = hy + ATTACK_HEIGHT;
    case (face)
      FACE_RIGHT: ax = hx + SQUARE_SIDE;
      FACE_LEFT:  ax = sub_clamp(hx, ATTACK_WIDTH);
      FACE_UP:    ay = sub_clamp(hy, ATTACK_WIDTH);
      FACE_DOWN:  ay = hy + SQUARE_SIDE;
      default:    ;
    endcase
  end

endmodule

// File: rtl/hero_attack_ctl.sv
// hero_attack_ctl: attack rectangle generator for both heroes on the game tick.
// Optional build macro ATTACK_HOLD_EN: a held button auto-repeats every
// ACTIVE_TIME+COOLDOWN_TIME cycles; without it only rising edges fire.
module hero_attack_ctl
  import hero_attack_ctl_pkg::*;
#(
  parameter int ACTIVE_TIME   = 15,
  parameter int COOLDOWN_TIME = 30,
  parameter int MIRROR_H2     = 1
) (
  input  logic        clk_div,
  input  logic        rst,
  input  logic        attack_btn,
  input  logic [1:0]  facing,
  input  logic [23:0] hero_x_pos,
  input  logic [23:0] hero_y_pos,
  output logic [23:0] attack_x_pos,
  output logic [23:0] attack_y_pos,
  output logic        attack_direction,
  output logic        attack_active
);

  localparam logic [5:0] ACTIVE_LOAD = 6'(ACTIVE_TIME - 1);
  localparam logic [5:0] COOL_LOAD   = 6'(COOLDOWN_TIME - 1);

  logic        btn_sync_p0, btn_sync_p1, btn_prev_p2;
  logic        vld_p0, vld_p1;
  logic        armed;
  logic        trigger, enter_active;
  state_t      state;
  logic [5:0]  cnt;
  logic [1:0]  fac_lat, fac_sel, fac_h2;
  logic [11:0] ax1, ay1, ax2, ay2;

  // Two-flop synchroniser plus edge history; vld_pN marks real samples after reset,
  // and armed waits for a released button so a press held through reset never fires.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      btn_prev_p2 <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      armed       <= 1'b0;
    end else begin
      btn_sync_p0 <= attack_btn;
      btn_sync_p1 <= btn_sync_p0;
      btn_prev_p2 <= btn_sync_p1;
      vld_p0      <= 1'b1;
      vld_p1      <= vld_p0;
      if (vld_p1 && !btn_sync_p1) armed <= 1'b1;
    end
  end

  // Decide whether this edge starts a new attack.
  always_comb begin
`ifdef ATTACK_HOLD_EN
    trigger      = armed & btn_sync_p1;
    enter_active = trigger & ((state == ST_READY) ||
                              ((state == ST_COOLDOWN) && (cnt == 6'd0)));
`else
    trigger      = armed & btn_sync_p1 & ~btn_prev_p2;
    enter_active = trigger & (state == ST_READY);
`endif
  end

  // While active the latched facing is used; otherwise the live one feeds a new entry.
  assign fac_sel = (state == ST_ACTIVE) ? fac_lat : facing;
  assign fac_h2  = (MIRROR_H2 != 0) ? mirror_facing(fac_sel) : fac_sel;

  attack_offset u_off_h1 (
    .hx   (hero_x_pos[11:0]),
    .hy   (hero_y_pos[11:0]),
    .face (fac_sel),
    .ax   (ax1),
    .ay   (ay1)
  );

  attack_offset u_off_h2 (
    .hx   (hero_x_pos[23:12]),
    .hy   (hero_y_pos[23:12]),
    .face (fac_h2),
    .ax   (ax2),
    .ay   (ay2)
  );

  // Attack FSM with shared down-counter and registered rectangle outputs.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state            <= ST_READY;
      cnt              <= 6'd0;
      fac_lat          <= 2'b00;
      attack_x_pos     <= {PARK_X, PARK_X};
      attack_y_pos     <= {PARK_Y, PARK_Y};
      attack_direction <= 1'b1;
      attack_active    <= 1'b0;
    end else if (enter_active) begin
      state            <= ST_ACTIVE;
      cnt              <= ACTIVE_LOAD;
      fac_lat          <= facing;
      attack_x_pos     <= {ax2, ax1};
      attack_y_pos     <= {ay2, ay1};
      attack_direction <= is_horizontal(facing);
      attack_active    <= 1'b1;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (cnt == 6'd0) begin
            state         <= ST_COOLDOWN;
            cnt           <= COOL_LOAD;
            attack_x_pos  <= {PARK_X, PARK_X};
            attack_y_pos  <= {PARK_Y, PARK_Y};
            attack_active <= 1'b0;
          end else begin
            cnt          <= cnt - 6'd1;
            attack_x_pos <= {ax2, ax1};
            attack_y_pos <= {ay2, ay1};
          end
        end
        ST_COOLDOWN: begin
          if (cnt == 6'd0) state <= ST_READY;
          else             cnt   <= cnt - 6'd1;
        end
        ST_READY: ;
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_hero_attack_ctl.sv
// Testbench for hero_attack_ctl: fixed vector table, hand-written timing
// sequences and randomized traffic, all checked every cycle against a
// timeline-based reference model.
module tb_hero_attack_ctl;

  logic        clk_div = 1'b0;
  logic        rst;
  logic        attack_btn;
  logic [1:0]  facing;
  logic [23:0] hero_x_pos, hero_y_pos;
  logic [23:0] attack_x_pos, attack_y_pos;
  logic        attack_direction, attack_active;

  hero_attack_ctl dut (
    .clk_div          (clk_div),
    .rst              (rst),
    .attack_btn       (attack_btn),
    .facing           (facing),
    .hero_x_pos       (hero_x_pos),
    .hero_y_pos       (hero_y_pos),
    .attack_x_pos     (attack_x_pos),
    .attack_y_pos     (attack_y_pos),
    .attack_direction (attack_direction),
    .attack_active    (attack_active)
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int errors = 0;
  int tcount = 0;

  // Reference model: button history per edge since reset, time of last fire.
  int n;
  int bq[$];
  int first_zero;
  int last_fire;
  int lat;
  int e_x1, e_y1, e_x2, e_y2;
  int e_dir, e_act;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Samples before the first post-reset edge count as "pressed".
  function automatic int bval(input int k);
    return (k < 1) ? 1 : bq[k-1];
  endfunction

  function automatic void ref_rect(input int hx, input int hy, input int f,
                                   output int ax, output int ay);
    ax = hx + 20;
    ay = hy + 20;
    case (f)
      2: ax = hx + 60;
      1: ax = (hx < 40) ? 0 : hx - 40;
      0: ay = (hy < 40) ? 0 : hy - 40;
      default: ay = hy + 60;
    endcase
  endfunction

  function automatic int mirror(input int f);
    return (f == 1) ? 2 : (f == 2) ? 1 : f;
  endfunction

  task automatic model_reset();
    n = 0;
    bq.delete();
    first_zero = 1 << 30;
    last_fire  = -1000;
    lat   = 0;
    e_dir = 1;
    e_act = 0;
    e_x1 = 1100; e_x2 = 1100; e_y1 = 0; e_y2 = 0;
  endtask

  task automatic model_edge();
    bit trig, can;
    n++;
    bq.push_back(int'(attack_btn));
    if (!attack_btn && first_zero > n) first_zero = n;
`ifdef ATTACK_HOLD_EN
    trig = (bval(n-2) == 1) && (first_zero <= n-3);
    can  = (n >= last_fire + 45);
`else
    trig = (bval(n-2) == 1) && (bval(n-3) == 0);
    can  = (n >= last_fire + 46);
`endif
    if (trig && can) begin
      last_fire = n;
      lat = int'(facing);
    end
    e_act = (n <= last_fire + 14) ? 1 : 0;
    if (e_act == 1) begin
      ref_rect(int'(hero_x_pos[11:0]), int'(hero_y_pos[11:0]), lat, e_x1, e_y1);
      ref_rect(int'(hero_x_pos[23:12]), int'(hero_y_pos[23:12]), mirror(lat), e_x2, e_y2);
      e_dir = (lat == 1 || lat == 2) ? 1 : 0;
    end else begin
      e_x1 = 1100; e_x2 = 1100; e_y1 = 0; e_y2 = 0;
    end
  endtask

  task automatic check_outputs();
    check("active", int'(attack_active), e_act);
    check("x_pos", int'(attack_x_pos), e_x2 * 4096 + e_x1);
    check("y_pos", int'(attack_y_pos), e_y2 * 4096 + e_y1);
    check("dir", int'(attack_direction), e_dir);
  endtask

  task automatic tick();
    @(posedge clk_div);
    if (!rst) model_edge();
    tcount++;
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Wait for attack_active with a bounded budget.
  task automatic wait_active(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (attack_active) ok = 1;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic set_heroes(input int hx1, input int hy1, input int hx2, input int hy2);
    hero_x_pos = {12'(hx2), 12'(hx1)};
    hero_y_pos = {12'(hy2), 12'(hy1)};
  endtask

  typedef struct {
    int hx1, hy1, hx2, hy2, f;
    int x1, y1, x2, y2, dir;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len, f0, acts, prev_act;

    tbl[0] = '{300, 200, 600, 200, 2,  360, 220, 560, 220, 1};
    tbl[1] = '{300, 200, 600, 200, 0,  320, 160, 620, 160, 0};
    tbl[2] = '{300, 200, 600, 200, 3,  320, 260, 620, 260, 0};
    tbl[3] = '{ 20, 200, 600, 300, 1,    0, 220, 660, 320, 1};
    tbl[4] = '{300,  30, 100,  39, 0,  320,   0, 120,   0, 0};
    tbl[5] = '{ 40, 108, 962, 708, 1,    0, 128,1022, 728, 1};

    rst = 1'b1;
    attack_btn = 1'b0;
    facing = 2'b00;
    set_heroes(300, 200, 600, 200);
    model_reset();
    #1;
    check("reset_x", int'(attack_x_pos), 1100 * 4096 + 1100);
    check("reset_y", int'(attack_y_pos), 0);
    check("reset_dir", int'(attack_direction), 1);
    check("reset_active", int'(attack_active), 0);
    @(negedge clk_div);
    @(negedge clk_div);
    rst = 1'b0;
    ticks(5);

    // Vector table: one attack per row, fixed geometry expectations.
    for (int r = 0; r < 6; r++) begin
      set_heroes(tbl[r].hx1, tbl[r].hy1, tbl[r].hx2, tbl[r].hy2);
      facing = 2'(tbl[r].f);
      attack_btn = 1'b1;
      wait_active("tbl", ok);
      if (ok) begin
        check("tbl_x1", int'(attack_x_pos[11:0]), tbl[r].x1);
        check("tbl_y1", int'(attack_y_pos[11:0]), tbl[r].y1);
        check("tbl_x2", int'(attack_x_pos[23:12]), tbl[r].x2);
        check("tbl_y2", int'(attack_y_pos[23:12]), tbl[r].y2);
        check("tbl_dir", int'(attack_direction), tbl[r].dir);
        attack_btn = 1'b0;
        facing = ~facing;
        len = 1;
        for (int i = 0; i < 40; i++) begin
          tick();
          if (attack_active) len++;
          else break;
        end
        check("tbl_active_len", len, 15);
        check("tbl_park_x", int'(attack_x_pos), 1100 * 4096 + 1100);
      end
      attack_btn = 1'b0;
      ticks(35);
    end

    // Press during cooldown is dropped; a press right after READY fires.
    set_heroes(300, 200, 600, 200);
    facing = 2'b10;
    attack_btn = 1'b1;
    wait_active("cd", ok);
    f0 = tcount;
    attack_btn = 1'b0;
    while (tcount < f0 + 19) tick();
    attack_btn = 1'b1;
    ticks(2);
    attack_btn = 1'b0;
    acts = 0;
    while (tcount < f0 + 44) begin
      tick();
      if (attack_active) acts++;
    end
    check("cooldown_press_ignored", acts, 0);
    attack_btn = 1'b1;
    ticks(2);
    check("not_yet_ready", int'(attack_active), 0);
    tick();
    check("ready_press_fires", int'(attack_active), 1);
    attack_btn = 1'b0;
    ticks(50);

    // Reset mid-attack parks immediately; a button held through reset stays quiet.
    attack_btn = 1'b1;
    wait_active("rst", ok);
    ticks(5);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_active", int'(attack_active), 0);
    check("rst_mid_x", int'(attack_x_pos), 1100 * 4096 + 1100);
    check("rst_mid_y", int'(attack_y_pos), 0);
    ticks(2);
    rst = 1'b0;
    acts = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (attack_active) acts++;
    end
    check("held_through_reset", acts, 0);
    attack_btn = 1'b0;
    ticks(5);
    attack_btn = 1'b1;
    wait_active("repress", ok);
    check("repress_fires", int'(ok), 1);
    attack_btn = 1'b0;
    ticks(50);

    // Held button: one attack, or auto-repeat every 45 cycles with hold enabled.
    attack_btn = 1'b1;
    acts = 0;
    prev_act = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (attack_active && prev_act == 0) acts++;
      prev_act = int'(attack_active);
    end
`ifdef ATTACK_HOLD_EN
    check("held_attacks", acts, 4);
`else
    check("held_attacks", acts, 1);
`endif
    attack_btn = 1'b0;
    ticks(50);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      set_heroes(int'($urandom_range(962, 62)), int'($urandom_range(708, 108)),
                 int'($urandom_range(962, 62)), int'($urandom_range(708, 108)));
      if ($urandom_range(7, 0) == 0) facing = 2'($urandom_range(3, 0));
      if ($urandom_range(5, 0) == 0) attack_btn = ~attack_btn;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
